dct_transpose_buffer: RTL
=========================

Name: dct_transpose_buffer

Overview:
- Sits directly downstream of the 1D DCT2 output permutation stage.
- Collects one transform block of row results, arriving as packed 512-bit vectors one row per handshake.
- Re-emits the block column by column in the same packed format, so the second-pass 1D DCT2 can consume it unchanged.
- Single buffer, fill-then-drain; the block size is selected by the same 2-bit N code used by the rest of the 1D datapath.

Parameters:
- DW, 16, signed coefficient width in bits.
- NMAX, 32, maximum transform length; the packed vector is DW*NMAX bits.

Ports:
- clk  in  1  system clock; everything on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_row/in_n valid.
- in_ready  out  1  buffer accepts a row.
- in_row  in  DW*NMAX  packed row; element k at bits [DW*NMAX-1-DW*k -: DW]; element 0 at the MSBs; unused low elements are zero.
- in_n  in  2  size code: 0=32, 1=16, 2=8, 3=4 (L = 32>>in_n).
- out_valid  out  1  out_col/out_n/out_last valid.
- out_ready  in  1  downstream accepts a column.
- out_col  out  DW*NMAX  packed column, same packing as in_row; element k = row k of the stored block; elements k>=L are zero.
- out_n  out  2  size code of the block being drained.
- out_last  out  1  marks column L-1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Handshakes: a transfer occurs on a cycle where valid && ready. A source holds data stable while valid && !ready. All outputs are registered.
- Reset values: in_ready=0 while rst is high; out_valid=0, out_col=0, out_n=0, out_last=0. State=FILL with row counter 0, so in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: the partial block or drain is discarded. Storage contents need not be cleared.
- FILL state:
  - in_ready=1.
  - The accepted row r is written to storage row r, elements 0..L-1; elements >= L are ignored.
  - in_n is latched on the first row (r=0) only; later in_n values within the block are ignored.
  - When row L-1 is accepted at cycle t, go to DRAIN. out_valid=1 at t+1 with column 0 and out_n = latched code.
- DRAIN state:
  - in_ready=0.
  - out_col element k = stored[k][c] for k<L, zero otherwise; c = column counter.
  - On each out transfer, c increments and out_col reloads the next column in the following cycle (no bubble when out_ready stays high).
  - out_last=1 exactly when c=L-1.
  - On acceptance of column L-1: out_valid=0 and state=FILL next cycle, so in_ready=1 next cycle.
  - Outputs stay frozen while out_ready=0.
- Latency and throughput:
  - First column valid 1 cycle after the last row is accepted.
  - L cycles to fill plus L cycles to drain at full rate.
  - Row and column transfers never occur in the same cycle.
- Data is moved bit-exact: no arithmetic, rounding, sign change or saturation; signed values pass through unchanged.
- Counters are 5 bits and wrap only through state transitions; a counter never exceeds L-1.

Decomposition:
- Shared package dct_pkg:
  - DW and NMAX constants.
  - Size-code typedef (2-bit enum SZ32=0, SZ16=1, SZ8=2, SZ4=3).
  - Function len_of(code) returning L.
  - Packed-vector typedef, plus element get/set helper functions that implement the MSB-first packing.
- One sub-module: dct_col_extract, purely combinational. It takes the storage array, column index and L, and returns the zero-padded packed column.

Test Plan:
- N=3, rows r=0..3, element c = 4r+c, out_ready=1 → columns at t+1..t+4; column c elements = {c, 4+c, 8+c, 12+c}, rest zero; out_last only on 4th; in_ready high at t+5.
- N=0, element = 32r+c (values 0..1023) → 32 columns; column 5 element 31 = 997; out_n=0; zero bubbles.
- N=2 with negative data (element = -(8r+c)-1) and out_ready toggling 1,0,0,1 → out_col/out_last stable while stalled; signed values exact (column 0 element 7 = -57).
- in_n switches 2→3 after first row of an 8-point block → block still takes 8 rows and drains 8 columns with out_n=2.
- rst asserted after 10 of 16 rows (N=1) → next cycle in_ready=0, out_valid=0; after release a fresh N=3 block drains correctly with no residue from the aborted block.
- Back-to-back blocks N=3 then N=1 with in_valid always high → in_ready=0 throughout the first drain, second block starts the cycle after the first out_last is accepted.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants, size-code type and packed-vector helpers for the 1D DCT datapath.
// Element 0 of a packed vector occupies the most significant DW bits.
package dct_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NMAX = 32;

  typedef enum logic [1:0] {
    SZ32 = 2'd0,
    SZ16 = 2'd1,
    SZ8  = 2'd2,
    SZ4  = 2'd3
  } sz_e;

  typedef logic [DW-1:0]            elem_t;
  typedef logic [NMAX-1:0][DW-1:0]  vec_t;

  function automatic logic [5:0] len_of(sz_e code);
    return 6'd32 >> code;
  endfunction

  // Element k lives in the packed slot NMAX-1-k.
  function automatic elem_t get_elem(vec_t v, logic [4:0] k);
    return v[5'(NMAX - 1) - k];
  endfunction

  function automatic vec_t set_elem(vec_t v, logic [4:0] k, elem_t e);
    vec_t r;
    r = v;
    r[5'(NMAX - 1) - k] = e;
    return r;
  endfunction

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out stream bundle of the transpose buffer.
// slave is the buffer side, master is the producer/consumer side.
interface dct_transpose_buffer_if;

  logic          in_valid;
  logic          in_ready;
  dct_pkg::vec_t in_row;
  dct_pkg::sz_e  in_n;

  logic          out_valid;
  logic          out_ready;
  dct_pkg::vec_t out_col;
  dct_pkg::sz_e  out_n;
  logic          out_last;

  modport slave (
    input  in_valid, in_row, in_n, out_ready,
    output in_ready, out_valid, out_col, out_n, out_last
  );

  modport master (
    output in_valid, in_row, in_n, out_ready,
    input  in_ready, out_valid, out_col, out_n, out_last
  );

endinterface

// File: rtl/dct_col_extract.sv
// Combinational column gather: element k = rows_i[k][col_i] for k < len_i, zero above.
module dct_col_extract
  import dct_pkg::*;
(
  input  vec_t       rows_i [NMAX],
  input  logic [4:0] col_i,
  input  logic [5:0] len_i,
  output vec_t       col_o
);

  always_comb begin
    col_o = '0;
    for (int k = 0; k < int'(NMAX); k++) begin
      if (6'(k) < len_i) begin
        col_o = set_elem(col_o, 5'(k), get_elem(rows_i[k], col_i));
      end
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Single-buffer block transpose: fills L rows, then drains L columns in the same packing.
// All stream outputs are registered; rows and columns never transfer in the same cycle.
module dct_transpose_buffer
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dct_transpose_buffer_if.slave bus
);

  typedef enum logic {StFill, StDrain} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  sz_e        n_q, n_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  vec_t       out_col_q, out_col_d;
  sz_e        out_n_q, out_n_d;
  logic       out_last_q, out_last_d;

  vec_t       mem_q [NMAX];
  vec_t       mem_d [NMAX];

  logic       in_fire, out_fire;
  sz_e        n_eff;
  logic [4:0] col_sel;
  logic [5:0] len_sel;
  vec_t       col_data;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  // The size code is only taken from the first row of a block.
  assign n_eff = (cnt_q == 5'd0) ? bus.in_n : n_q;

  // Column 0 is gathered from the storage view that already includes the last row.
  always_comb begin
    mem_d = mem_q;
    if (in_fire) begin
      mem_d[cnt_q] = bus.in_row;
    end
  end

  assign col_sel = (state_q == StDrain) ? cnt_q + 5'd1 : 5'd0;
  assign len_sel = len_of((state_q == StFill) ? n_eff : n_q);

  dct_col_extract u_col_extract (
    .rows_i (mem_d),
    .col_i  (col_sel),
    .len_i  (len_sel),
    .col_o  (col_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_n_d     = out_n_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      StFill: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          n_d = n_eff;
          if ({1'b0, cnt_q} == len_sel - 6'd1) begin
            state_d     = StDrain;
            cnt_d       = 5'd0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_col_d   = col_data;
            out_n_d     = n_eff;
            out_last_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StDrain: begin
        in_ready_d = 1'b0;
        if (out_fire) begin
          if (out_last_q) begin
            state_d     = StFill;
            cnt_d       = 5'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_col_d   = '0;
            out_last_d  = 1'b0;
          end else begin
            cnt_d      = cnt_q + 5'd1;
            out_col_d  = col_data;
            out_last_d = ({1'b0, cnt_q} + 6'd2 == len_of(n_q));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      cnt_q       <= 5'd0;
      n_q         <= SZ32;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_n_q     <= SZ32;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_n_q     <= out_n_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_n     = out_n_q;
  assign bus.out_last  = out_last_q;

endmodule
